iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
Parametrised multi-cycle shift/rotate unit, the successor to the fixed single-cycle SHR/SHRA datapath path. It supports logical right, arithmetic right, left, rotate-right and rotate-left on a WIDTH-bit operand. Each clock it shifts by up to STEP bit positions, trading latency for area. It sits beside the ALU: the control unit pulses start, waits for done, then drives result onto the bus via Zlow.

Parameters:
WIDTH, 32, operand/result width in bits.
STEP, 4, maximum bit positions shifted per clock; a power of two, 1..WIDTH.
SHAMT_W, $clog2(WIDTH), width of the shift-amount port.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled on the rising edge.
mode  input  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101–111 illegal.
operand  input  WIDTH  value to shift; sampled with start.
shamt  input  SHAMT_W  shift amount; sampled with start.
result  output  WIDTH  shifted value; registered and held until the next accepted start.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle completion pulse (registered).
err  output  1  illegal mode flag for the last accepted operation; held.

Behaviour:
- Reset: clear high asynchronously forces the following, regardless of state:
  - state=IDLE
  - result=0, busy=0, done=0, err=0
  - internal working register and remaining count cleared.
- States:
  - IDLE: waiting.
  - SHIFT: iterating.
  - DONE: one cycle, done=1.
- Start acceptance:
  - start is accepted only in IDLE or DONE, which allows back-to-back operations.
  - start is ignored while in SHIFT. No queuing, and no effect on the in-flight operation.
- On accept (edge E0):
  - Latch mode into an internal register.
  - Load work=operand and rem=shamt. shamt is inherently modulo WIDTH, because only SHAMT_W bits exist (WIDTH a power of two).
  - Illegal mode: result=operand, err=1, next state DONE.
  - Legal mode with rem=0: result=operand, err=0, next state DONE.
  - Otherwise: err=0, next state SHIFT.
- In SHIFT, each edge:
  - Compute k = min(rem, STEP).
  - Shift work by k per the latched mode:
    - SHR: fill with 0.
    - SHRA: replicate work[WIDTH-1].
    - SHL: fill with 0.
    - ROR/ROL: rotate, no bit loss.
  - rem -= k.
  - If the new rem=0: result=shifted work, next state DONE.
- Latency: done is high during the cycle following edge E_n, where n = ceil(shamt/STEP).
  - shamt=0 or illegal mode: done follows E0 directly.
  - busy=1 for exactly n-1 cycles between E1 and E_{n-1}; it is never high when n≤1 beyond the SHIFT cycles.
- DONE: done=1 for exactly one cycle, then IDLE, unless start is accepted in that same cycle.
- Outputs:
  - result is updated only on entering DONE.
  - Intermediate work values are never visible on result.
- Operand/shamt changes after E0 have no effect on the in-flight operation.
- clear mid-operation: the operation is abandoned, there is no done pulse, and all outputs go to 0. The next start after clear deasserts behaves normally.
- Arithmetic rules:
  - SHRA on a negative operand with shamt=WIDTH-1 yields all ones.
  - ROR by r equals ROL by WIDTH-r.
  - Width rule: shifting uses only bits [WIDTH-1:0]; no carry or overflow output.

Test Plan:
1. WIDTH=32, STEP=4: SHRA operand=0xFFFFFFDE, shamt=3 -> done after E1, result=0xFFFFFFFB, err=0, busy never high.
2. SHR operand=0x80000000, shamt=31 -> busy high for 7 cycles, done after E8, result=0x00000001.
3. ROL operand=0x12345678, shamt=8 -> done after E2, result=0x34567812. Then immediately, in the DONE cycle, start ROR operand=0x00000001, shamt=1 -> done after E1, result=0x80000000.
4. SHL operand=0x00000028, shamt=0 -> done after E0, result=0x00000028. Then mode=3'b111, operand=0xA5A5A5A5 -> done after E0, result=0xA5A5A5A5, err=1.
5. Start SHR operand=0xFFFFFFFF, shamt=20. Assert start again at E2 with different values -> ignored; result=0x00000FFF after E5. Repeat with clear high between edges at E3 -> result=0, done=0, busy=0 immediately, and no done pulse follows.
6. STEP=1 build: SHRA operand=0x80000000, shamt=31 -> done after E31, result=0xFFFFFFFF.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit. Shifts a WIDTH-bit operand by up to STEP
// bit positions per clock until the requested amount has been applied.
// The final value is published on result together with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | iterating; work/rem hold the in-flight operand and remaining amount
// DONE  | result valid, done=1 for this cycle; a new start may be accepted here
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_SHR  = 3'd0;
  localparam logic [2:0] MODE_SHRA = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;

  // One extra bit so that STEP == WIDTH still compares correctly against rem.
  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

  state_t               state;
  logic [2:0]           mode_q;
  logic [WIDTH-1:0]     work;
  logic [SHAMT_W-1:0]   rem;

  logic [SHAMT_W-1:0]   step_k;
  logic [SHAMT_W-1:0]   rem_next;
  logic [WIDTH-1:0]     work_next;
  logic [2*WIDTH-1:0]   rot_r;
  logic [2*WIDTH-1:0]   rot_l;

  // Next work/rem for one iteration: shift by k = min(rem, STEP).
  always_comb begin
    step_k    = '0;
    rem_next  = '0;
    work_next = work;
    rot_r     = '0;
    rot_l     = '0;
    // When rem >= STEP, STEP <= WIDTH-1 and fits the SHAMT_W-bit slice.
    if ({1'b0, rem} < STEP_C) begin
      step_k = rem;
    end else begin
      step_k = STEP_C[SHAMT_W-1:0];
    end
    rem_next = rem - step_k;
    rot_r    = {work, work} >> step_k;
    rot_l    = {work, work} << step_k;
    case (mode_q)
      MODE_SHR:  work_next = work >> step_k;
      MODE_SHRA: work_next = $signed(work) >>> step_k;
      MODE_SHL:  work_next = work << step_k;
      MODE_ROR:  work_next = rot_r[WIDTH-1:0];
      MODE_ROL:  work_next = rot_l[2*WIDTH-1:WIDTH];
      default:   work_next = work;
    endcase
  end

  // Control FSM with registered outputs; result only changes on entry to DONE.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      mode_q <= '0;
      work   <= '0;
      rem    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mode_q <= mode;
            work   <= operand;
            rem    <= shamt;
            if (mode > MODE_ROL) begin
              result <= operand;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else if (shamt == '0) begin
              result <= operand;
              err    <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              err    <= 1'b0;
              state  <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= work_next;
          rem  <= rem_next;
          if (rem_next == '0) begin
            result <= work_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            // busy is only raised once an iteration leaves work outstanding,
            // so single-iteration operations never show busy.
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: a STEP=4 instance and a STEP=1 instance.
module tb_iter_shifter;

  logic        Clock;
  logic        clear;
  logic        start0;
  logic        start1;
  logic [2:0]  mode;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic [31:0] result0, result1;
  logic        busy0, busy1, done0, done1, err0, err1;

  int checks = 0;
  int errors = 0;

  iter_shifter #(.WIDTH(32), .STEP(4)) dut0 (
    .Clock(Clock), .clear(clear), .start(start0), .mode(mode),
    .operand(operand), .shamt(shamt), .result(result0),
    .busy(busy0), .done(done0), .err(err0)
  );

  iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .Clock(Clock), .clear(clear), .start(start1), .mode(mode),
    .operand(operand), .shamt(shamt), .result(result1),
    .busy(busy1), .done(done1), .err(err1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives start for one edge (E0) from the current time, scrambles the
  // inputs afterwards, and counts edges after E0 until done is seen.
  task automatic run_op(input bit sel, input logic [2:0] m, input logic [31:0] op,
                        input logic [4:0] sa, output int edges, output int bcnt);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    mode = m; operand = op; shamt = sa;
    @(posedge Clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    operand = 32'hDEADBEEF; shamt = 5'd13; mode = 3'd2;
    edges = 0; bcnt = 0;
    while (!(sel ? done1 : done0) && edges < 200) begin
      if (sel ? busy1 : busy0) bcnt++;
      @(posedge Clock); #1;
      edges++;
    end
  endtask

  int e, b, cnt;

  initial begin
    clear = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode = 3'd0; operand = '0; shamt = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_result", result0, 32'h0);
    check("rst_busy", {31'b0, busy0}, 32'h0);
    check("rst_done", {31'b0, done0}, 32'h0);
    check("rst_err", {31'b0, err0}, 32'h0);
    @(negedge Clock); clear = 1'b0;
    @(posedge Clock); #1;

    // 1: SHRA, n=1, busy never high
    run_op(0, 3'd1, 32'hFFFFFFDE, 5'd3, e, b);
    check("t1_edges", e, 1);
    check("t1_result", result0, 32'hFFFFFFFB);
    check("t1_err", {31'b0, err0}, 32'h0);
    check("t1_busy", b, 0);
    @(posedge Clock); #1;
    check("t1_done_pulse", {31'b0, done0}, 32'h0);
    check("t1_hold", result0, 32'hFFFFFFFB);

    // 2: SHR by 31, n=8, busy for 7 cycles
    run_op(0, 3'd0, 32'h80000000, 5'd31, e, b);
    check("t2_edges", e, 8);
    check("t2_busy", b, 7);
    check("t2_result", result0, 32'h00000001);
    @(posedge Clock); #1;
    check("t2_done_pulse", {31'b0, done0}, 32'h0);
    check("t2_busy_after", {31'b0, busy0}, 32'h0);

    // 3: ROL then back-to-back ROR issued in the DONE cycle
    run_op(0, 3'd4, 32'h12345678, 5'd8, e, b);
    check("t3_rol_edges", e, 2);
    check("t3_rol_result", result0, 32'h34567812);
    run_op(0, 3'd3, 32'h00000001, 5'd1, e, b);
    check("t3_ror_edges", e, 1);
    check("t3_ror_result", result0, 32'h80000000);
    @(posedge Clock); #1;

    // ROL by WIDTH-1 equals ROR by 1
    run_op(0, 3'd4, 32'h00000001, 5'd31, e, b);
    check("rol31_result", result0, 32'h80000000);
    check("rol31_edges", e, 8);
    // SHRA negative by WIDTH-1 gives all ones; positive gives zero
    run_op(0, 3'd1, 32'h80000000, 5'd31, e, b);
    check("shra_neg31", result0, 32'hFFFFFFFF);
    run_op(0, 3'd1, 32'h7FFFFFFF, 5'd31, e, b);
    check("shra_pos31", result0, 32'h00000000);
    run_op(0, 3'd2, 32'h0000000F, 5'd30, e, b);
    check("shl30", result0, 32'hC0000000);
    @(posedge Clock); #1;

    // 4: shamt=0 and illegal mode complete right after E0
    run_op(0, 3'd2, 32'h00000028, 5'd0, e, b);
    check("t4_zero_edges", e, 0);
    check("t4_zero_result", result0, 32'h00000028);
    check("t4_zero_err", {31'b0, err0}, 32'h0);
    run_op(0, 3'd7, 32'hA5A5A5A5, 5'd7, e, b);
    check("t4_ill_edges", e, 0);
    check("t4_ill_result", result0, 32'hA5A5A5A5);
    check("t4_ill_err", {31'b0, err0}, 32'h1);
    @(posedge Clock); #1;
    check("t4_err_held", {31'b0, err0}, 32'h1);
    check("t4_busy", {31'b0, busy0}, 32'h0);

    // 5a: start during SHIFT is ignored
    start0 = 1'b1; mode = 3'd0; operand = 32'hFFFFFFFF; shamt = 5'd20;
    @(posedge Clock); #1;               // E0
    start0 = 1'b0; operand = 32'h0; shamt = 5'd0;
    @(posedge Clock); #1;               // E1
    start0 = 1'b1; mode = 3'd2; operand = 32'h00000001; shamt = 5'd1;
    @(posedge Clock); #1;               // E2
    start0 = 1'b0;
    check("t5_busy_e2", {31'b0, busy0}, 32'h1);
    @(posedge Clock); #1;               // E3
    @(posedge Clock); #1;               // E4
    check("t5_done_e4", {31'b0, done0}, 32'h0);
    @(posedge Clock); #1;               // E5
    check("t5_done_e5", {31'b0, done0}, 32'h1);
    check("t5_result", result0, 32'h00000FFF);
    check("t5_err", {31'b0, err0}, 32'h0);
    @(posedge Clock); #1;

    // 5b: clear mid-operation abandons it
    start0 = 1'b1; mode = 3'd0; operand = 32'hFFFFFFFF; shamt = 5'd20;
    @(posedge Clock); #1;               // E0
    start0 = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end   // E1..E3
    #2 clear = 1'b1;
    #1;
    check("t5_clr_result", result0, 32'h0);
    check("t5_clr_done", {31'b0, done0}, 32'h0);
    check("t5_clr_busy", {31'b0, busy0}, 32'h0);
    @(negedge Clock); clear = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge Clock); #1;
      if (done0) cnt++;
    end
    check("t5_no_done", cnt, 0);
    run_op(0, 3'd2, 32'h00000001, 5'd5, e, b);
    check("t5_post_edges", e, 2);
    check("t5_post_result", result0, 32'h00000020);
    @(posedge Clock); #1;

    // 6: STEP=1 instance, SHRA by 31
    run_op(1, 3'd1, 32'h80000000, 5'd31, e, b);
    check("t6_edges", e, 31);
    check("t6_busy", b, 30);
    check("t6_result", result1, 32'hFFFFFFFF);
    check("t6_err", {31'b0, err1}, 32'h0);
    @(posedge Clock); #1;
    check("t6_done_pulse", {31'b0, done1}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
